// File: rtl/mac_array_param.sv
// mac_array_param
//   Parametrised output-stationary systolic MAC array (ROWS x COLS PEs).
//   The block skews the operand lanes internally. A K-length sequencer
//   accepts operand beats over a valid/ready handshake. Latched row and
//   column masks gate each PE. A done pulse marks the cycle the results
//   become final.
//
//   Optional feature: define MACARRAY_SAT_EN to make accumulators saturate
//   and to expose a sticky per-PE sat_flag output. Otherwise accumulators
//   wrap modulo 2^AW and sat_flag does not exist.
//
// Ports
//   CLK, RSTN   clock (rising edge), asynchronous active-low reset
//   start       begin a job (honoured only in IDLE or DONE)
//   k_len       reduction length, clamped to K_MAX, sampled with start
//   row_en      row mask, sampled with start
//   col_en      column mask, sampled with start
//   in_valid    a_vec/b_vec beat valid
//   in_ready    high in LOAD
//   a_vec       A column k, row i at [i*DW +: DW]
//   b_vec       B row k, column j at [j*DW +: DW]
//   busy        high in LOAD and DRAIN
//   done        one-cycle pulse on entry to DONE
//   c_flat      PE(i,j) accumulator at [(i*COLS+j)*AW +: AW]
//   sat_flag    (MACARRAY_SAT_EN only) sticky clip flag per PE
module mac_array_param #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DW    = 4,
  parameter int AW    = 20,
  parameter int K_MAX = 255,
  parameter int KW    = 8
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  input  logic [ROWS-1:0]         row_en,
  input  logic [COLS-1:0]         col_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*DW-1:0]      a_vec,
  input  logic [COLS*DW-1:0]      b_vec,
  output logic                    busy,
  output logic                    done,
  output logic [ROWS*COLS*AW-1:0] c_flat
`ifdef MACARRAY_SAT_EN
  ,
  output logic [ROWS*COLS-1:0]    sat_flag
`endif
);

  if (AW < 2*DW + $clog2(K_MAX)) begin : g_chk_aw
    $error("mac_array_param: AW too small for DW and K_MAX");
  end
  if ((2**KW) <= K_MAX) begin : g_chk_kw
    $error("mac_array_param: KW cannot represent K_MAX");
  end

  // DRAIN lasts ROWS+COLS-1 cycles; counter runs 0 .. ROWS+COLS-2
  localparam int DCW = (ROWS + COLS > 2) ? $clog2(ROWS + COLS - 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   beat_cnt;
  logic [DCW-1:0]  drain_cnt;
  logic [ROWS-1:0] row_en_q;
  logic [COLS-1:0] col_en_q;
  logic [KW-1:0]   k_clamp;
  logic            job_start;
  logic            accept;

  assign job_start = start && (state == S_IDLE || state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign k_clamp   = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      k_q       <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      row_en_q  <= '0;
      col_en_q  <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            k_q       <= k_clamp;
            row_en_q  <= row_en;
            col_en_q  <= col_en;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            busy      <= 1'b1;
            if (k_clamp == '0) begin
              state    <= S_DRAIN;
              in_ready <= 1'b0;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (beat_cnt == k_q - KW'(1)) begin
              state     <= S_DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + KW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DCW'(ROWS + COLS - 2)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand buses: a_bus[i][0] is the skewed edge input of row i,
  // a_bus[i][j+1] is the A register leaving PE(i,j). Same scheme for B down
  // the columns. The final bus entries leave the array unused.
  logic signed [DW-1:0] a_bus   [ROWS][COLS+1];
  logic                 a_bus_v [ROWS][COLS+1];
  logic signed [DW-1:0] b_bus   [ROWS+1][COLS];
  logic                 b_bus_v [ROWS+1][COLS];
  logic signed [AW-1:0] acc_w   [ROWS][COLS];
`ifdef MACARRAY_SAT_EN
  logic                 sat_w   [ROWS][COLS];
`endif

  // Row i sees i+1 registers before PE(i,0); the first stage is the input
  // capture, so beat t reaches PE(i,j) in cycle t+i+j+1.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
    logic [gi:0][DW-1:0] d;
    logic [gi:0]         v;
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        d <= '0;
        v <= '0;
      end else if (job_start) begin
        d <= '0;
        v <= '0;
      end else begin
        d[0] <= accept ? a_vec[gi*DW +: DW] : '0;
        v[0] <= accept;
        for (int unsigned s = 1; s <= gi; s++) begin
          d[s] <= d[s-1];
          v[s] <= v[s-1];
        end
      end
    end
    assign a_bus[gi][0]   = d[gi];
    assign a_bus_v[gi][0] = v[gi];
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
    logic [gj:0][DW-1:0] d;
    logic [gj:0]         v;
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        d <= '0;
        v <= '0;
      end else if (job_start) begin
        d <= '0;
        v <= '0;
      end else begin
        d[0] <= accept ? b_vec[gj*DW +: DW] : '0;
        v[0] <= accept;
        for (int unsigned s = 1; s <= gj; s++) begin
          d[s] <= d[s-1];
          v[s] <= v[s-1];
        end
      end
    end
    assign b_bus[0][gj]   = d[gj];
    assign b_bus_v[0][gj] = v[gj];
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe
      logic signed [DW-1:0]   a_in, b_in, a_r, b_r;
      logic                   a_in_v, b_in_v, a_rv, b_rv;
      logic signed [2*DW-1:0] prod;
      logic signed [AW-1:0]   prod_x;
      logic signed [AW-1:0]   acc, acc_nx;
      logic                   en;

      assign a_in   = a_bus[gi][gj];
      assign a_in_v = a_bus_v[gi][gj];
      assign b_in   = b_bus[gi][gj];
      assign b_in_v = b_bus_v[gi][gj];
      assign prod   = a_in * b_in;
      assign prod_x = AW'(prod);
      assign en     = a_in_v && b_in_v && row_en_q[gi] && col_en_q[gj];

`ifdef MACARRAY_SAT_EN
      logic [AW:0] sum;
      logic        ovf;
      logic        sat_r;
      assign sum    = {acc[AW-1], acc} + {prod_x[AW-1], prod_x};
      assign ovf    = sum[AW] ^ sum[AW-1];
      assign acc_nx = !ovf    ? sum[AW-1:0] :
                      sum[AW] ? {1'b1, {(AW-1){1'b0}}} :
                                {1'b0, {(AW-1){1'b1}}};
`else
      assign acc_nx = acc + prod_x;
`endif

      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          a_r  <= '0;
          a_rv <= 1'b0;
          b_r  <= '0;
          b_rv <= 1'b0;
          acc  <= '0;
`ifdef MACARRAY_SAT_EN
          sat_r <= 1'b0;
`endif
        end else if (job_start) begin
          a_r  <= '0;
          a_rv <= 1'b0;
          b_r  <= '0;
          b_rv <= 1'b0;
          acc  <= '0;
`ifdef MACARRAY_SAT_EN
          sat_r <= 1'b0;
`endif
        end else begin
          a_r  <= a_in;
          a_rv <= a_in_v;
          b_r  <= b_in;
          b_rv <= b_in_v;
          if (en) acc <= acc_nx;
`ifdef MACARRAY_SAT_EN
          if (en && ovf) sat_r <= 1'b1;
`endif
        end
      end

      assign a_bus[gi][gj+1]   = a_r;
      assign a_bus_v[gi][gj+1] = a_rv;
      assign b_bus[gi+1][gj]   = b_r;
      assign b_bus_v[gi+1][gj] = b_rv;
      assign acc_w[gi][gj]     = acc;
`ifdef MACARRAY_SAT_EN
      assign sat_w[gi][gj]     = sat_r;
`endif
    end
  end

  always_comb begin
    c_flat = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      for (int unsigned j = 0; j < COLS; j++) begin
        c_flat[(i*COLS+j)*AW +: AW] = acc_w[i][j];
      end
    end
  end

`ifdef MACARRAY_SAT_EN
  always_comb begin
    sat_flag = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      for (int unsigned j = 0; j < COLS; j++) begin
        sat_flag[i*COLS+j] = sat_w[i][j];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_array_param.sv
// tb_mac_array_param
//   Directed bench for mac_array_param in its default 4x4, DW=4, AW=20
//   configuration. Expected matrices and cycle numbers are hand-computed;
//   cycle 0 is the cycle in which start is presented.
module tb_mac_array_param;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 4;
  localparam int AW = 20;
  localparam int KW = 8;

  logic              CLK = 1'b0;
  logic              RSTN;
  logic              start;
  logic [KW-1:0]     k_len;
  logic [R-1:0]      row_en;
  logic [C-1:0]      col_en;
  logic              in_valid;
  logic              in_ready;
  logic [R*DW-1:0]   a_vec;
  logic [C*DW-1:0]   b_vec;
  logic              busy;
  logic              done;
  logic [R*C*AW-1:0] c_flat;

  int n_checks = 0;
  int n_errors = 0;

  logic [R*DW-1:0] a_beats [8];
  logic [C*DW-1:0] b_beats [8];
  int              exp_c   [R][C];

  mac_array_param #(
    .ROWS(R), .COLS(C), .DW(DW), .AW(AW), .K_MAX(255), .KW(KW)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .k_len(k_len),
    .row_en(row_en), .col_en(col_en), .in_valid(in_valid),
    .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .busy(busy), .done(done), .c_flat(c_flat)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic longint c_at(input int i, input int j);
    logic signed [AW-1:0] v;
    v = c_flat[(i*C+j)*AW +: AW];
    return longint'(v);
  endfunction

  task automatic check_c(input string name);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        check($sformatf("%s_c%0d%0d", name, i, j), c_at(i, j), longint'(exp_c[i][j]));
  endtask

  task automatic set_identity();
    for (int t = 0; t < 8; t++) begin
      a_beats[t] = '0;
      b_beats[t] = '0;
    end
    for (int t = 0; t < 4; t++) a_beats[t][4*t +: 4] = 4'h1;
    b_beats[0] = 16'h4321;   // { 1, 2, 3, 4}
    b_beats[1] = 16'h8765;   // { 5, 6, 7,-8}
    b_beats[2] = 16'hCDEF;   // {-1,-2,-3,-4}
    b_beats[3] = 16'h1807;   // { 7, 0,-8, 1}
    exp_c = '{'{1, 2, 3, 4}, '{5, 6, 7, -8}, '{-1, -2, -3, -4}, '{7, 0, -8, 1}};
  endtask

  task automatic fill(input logic [15:0] a, input logic [15:0] b, input int v);
    for (int t = 0; t < 8; t++) begin
      a_beats[t] = a;
      b_beats[t] = b;
    end
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        exp_c[i][j] = v;
  endtask

  // Called at a negedge; presents start in that cycle (cycle 0) and runs
  // until done is seen. Beats go out only on cycles where in_ready is high.
  task automatic run_job(input string name, input int k,
                         input logic [R-1:0] re, input logic [C-1:0] ce,
                         input bit bubbles, input bit poke,
                         input int exp_done, input int exp_ready);
    int c, bi, busy_cnt, ready_cnt, done_cyc;
    c = 0; bi = 0; busy_cnt = 0; ready_cnt = 0; done_cyc = -1;
    start = 1'b1; k_len = KW'(k); row_en = re; col_en = ce;
    in_valid = 1'b0; a_vec = '0; b_vec = '0;
    while (done_cyc < 0 && c < 100) begin
      @(negedge CLK);
      c++;
      start = 1'b0; in_valid = 1'b0; a_vec = '0; b_vec = '0;
      if (done) begin
        done_cyc = c;
        check({name, "_busy_at_done"}, longint'(busy), 0);
      end else begin
        if (busy) busy_cnt++;
        if (in_ready) begin
          ready_cnt++;
          if (bi < k && (!bubbles || (c % 2) == 1)) begin
            in_valid = 1'b1;
            a_vec    = a_beats[bi];
            b_vec    = b_beats[bi];
            bi++;
          end
        end
        if (poke && c == 2) begin
          start = 1'b1; k_len = KW'(1); row_en = '1; col_en = '1;
        end
      end
    end
    check({name, "_done_cycle"}, done_cyc, exp_done);
    check({name, "_busy_cycles"}, busy_cnt, exp_done - 1);
    check({name, "_ready_cycles"}, ready_cnt, exp_ready);
  endtask

  initial begin
    int done_seen;
    RSTN = 1'b0; start = 1'b0; k_len = '0; row_en = '0; col_en = '0;
    in_valid = 1'b0; a_vec = '0; b_vec = '0;
    repeat (3) @(negedge CLK);
    check("rst_done", longint'(done), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_ready", longint'(in_ready), 0);
    check("rst_c_nonzero", longint'(|c_flat), 0);
    RSTN = 1'b1;
    @(negedge CLK);

    // Identity A: C must reproduce B; done at cycle k+R+C = 12
    set_identity();
    run_job("ident", 4, '1, '1, 1'b0, 1'b0, 12, 4);
    check_c("ident");

    // Back-to-back starts issued in the done cycle of the previous job
    fill(16'h8888, 16'h8888, 256);      // 4 * (-8 * -8)
    run_job("ext_pos", 4, '1, '1, 1'b0, 1'b0, 12, 4);
    check_c("ext_pos");
    fill(16'h8888, 16'h7777, -224);     // 4 * (-8 * 7)
    run_job("ext_neg", 4, '1, '1, 1'b0, 1'b0, 12, 4);
    check_c("ext_neg");

    // Alternate-cycle bubbles: 3 bubbles delay done from 12 to 15
    set_identity();
    run_job("bubble", 4, '1, '1, 1'b1, 1'b0, 15, 7);
    check_c("bubble");

    // Masks with a start pulse during LOAD that must be ignored
    fill(16'h1111, 16'h1111, 5);
    for (int j = 0; j < C; j++) exp_c[2][j] = 0;
    for (int i = 0; i < R; i++) exp_c[i][3] = 0;
    run_job("mask", 5, 4'b1011, 4'b0111, 1'b0, 1'b1, 13, 5);
    check_c("mask");

    // k_len = 0: pure drain, done at R+C = 8, previous results cleared
    fill(16'h1111, 16'h1111, 0);
    run_job("k0", 0, '1, '1, 1'b0, 1'b0, 8, 0);
    check_c("k0");

    // Reset asserted mid-DRAIN of a k_len=2 job
    set_identity();
    start = 1'b1; k_len = KW'(2); row_en = '1; col_en = '1;
    @(negedge CLK);                       // cycle 1
    start = 1'b0; in_valid = 1'b1; a_vec = a_beats[0]; b_vec = b_beats[0];
    @(negedge CLK);                       // cycle 2
    a_vec = a_beats[1]; b_vec = b_beats[1];
    @(negedge CLK);                       // cycle 3, DRAIN
    in_valid = 1'b0; a_vec = '0; b_vec = '0;
    check("mid_busy", longint'(busy), 1);
    check("mid_ready", longint'(in_ready), 0);
    @(negedge CLK);                       // cycle 4
    check("mid_c00", c_at(0, 0), 1);
    RSTN = 1'b0;
    #1;
    check("arst_c_nonzero", longint'(|c_flat), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_ready", longint'(in_ready), 0);
    check("arst_done", longint'(done), 0);
    @(negedge CLK);
    RSTN = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (done) done_seen++;
    end
    check("arst_no_done", done_seen, 0);
    check("arst_idle_busy", longint'(busy), 0);

    // Recovery from IDLE after the abort
    set_identity();
    run_job("recov", 4, '1, '1, 1'b0, 1'b0, 12, 4);
    check_c("recov");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
